// File: rtl/reg_file_sb_if.sv
// Bus bundle between decode and the scoreboarded register file. The master side is decode and
// writeback; the slave side is the register file.
interface reg_file_sb_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rd_addr1;
    logic              rd_use1;
    logic [WIDTH-1:0]  rd_data1;
    logic              busy1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_use2;
    logic [WIDTH-1:0]  rd_data2;
    logic              busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              stall;
    logic              iss_ack;

    modport master (
        output rd_addr1, rd_use1, rd_addr2, rd_use2,
        output wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data1, busy1, rd_data2, busy2, stall, iss_ack
    );

    modport slave (
        input  rd_addr1, rd_use1, rd_addr2, rd_use2,
        input  wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data1, busy1, rd_data2, busy2, stall, iss_ack
    );
endinterface

// File: rtl/reg_file_sb.sv
// Decode-stage register file: two combinational read ports, one write port, optional write
// bypass and a per-register pending bit that drives the stall request to the hazard unit.
module reg_file_sb #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  w_mem [DEPTH];
    logic [DEPTH-1:0]  w_pend;
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [WIDTH-1:0]  w_rd_data [2];
    logic [1:0]        w_rd_use;
    logic [1:0]        w_byp;
    logic [1:0]        w_busy;
    logic              w_stall;
    logic              w_iss_ack;

    assign w_rd_addr[0] = bus.rd_addr1;
    assign w_rd_addr[1] = bus.rd_addr2;
    assign w_rd_use     = {bus.rd_use2, bus.rd_use1};

    // Register 0 is kept at zero and never pending simply by masking its write and set strobes.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        logic [WIDTH-1:0] r_q;
        logic             r_pend;
        logic             w_masked;
        logic             w_wr;
        logic             w_set;

        assign w_masked = (ZERO_REG != 0) && (gi == 0);
        assign w_wr     = bus.wr_en && (bus.wr_addr == ADDR_W'(gi)) && !w_masked;
        assign w_set    = w_iss_ack && (bus.iss_addr == ADDR_W'(gi)) && !w_masked;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_q    <= '0;
                r_pend <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_q <= bus.wr_data;
                end
                // A same-cycle issue belongs to a newer producer, so it beats the clear.
                if (w_set) begin
                    r_pend <= 1'b1;
                end else if (w_wr) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign w_mem[gi]  = r_q;
        assign w_pend[gi] = r_pend;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        // Bypass is suppressed in reset so reads show the cleared storage.
        assign w_byp[gi] = (BYPASS != 0) && i_rst_n && bus.wr_en
                        && (bus.wr_addr == w_rd_addr[gi])
                        && !((ZERO_REG != 0) && (w_rd_addr[gi] == '0));
        assign w_rd_data[gi] = w_byp[gi] ? bus.wr_data : w_mem[w_rd_addr[gi]];
        assign w_busy[gi]    = i_rst_n && w_pend[w_rd_addr[gi]] && !w_byp[gi];
    end

    assign w_stall   = |(w_busy & w_rd_use);
    assign w_iss_ack = i_rst_n && bus.iss_en && !w_stall;

    assign bus.rd_data1 = w_rd_data[0];
    assign bus.rd_data2 = w_rd_data[1];
    assign bus.busy1    = w_busy[0];
    assign bus.busy2    = w_busy[1];
    assign bus.stall    = w_stall;
    assign bus.iss_ack  = w_iss_ack;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypassing and a non-bypassing instance share one stimulus.
module tb_reg_file_sb;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    reg_file_sb_if #(.WIDTH(16), .ADDR_W(4)) bus ();
    reg_file_sb_if #(.WIDTH(16), .ADDR_W(4)) bus_nb ();

    reg_file_sb #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    reg_file_sb #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus_nb.slave)
    );

    assign bus_nb.rd_addr1 = bus.rd_addr1;
    assign bus_nb.rd_use1  = bus.rd_use1;
    assign bus_nb.rd_addr2 = bus.rd_addr2;
    assign bus_nb.rd_use2  = bus.rd_use2;
    assign bus_nb.wr_en    = bus.wr_en;
    assign bus_nb.wr_addr  = bus.wr_addr;
    assign bus_nb.wr_data  = bus.wr_data;
    assign bus_nb.iss_en   = bus.iss_en;
    assign bus_nb.iss_addr = bus.iss_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
        $display("check %-14s got %h exp %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_addr1 = '0; bus.rd_use1 = 1'b0;
        bus.rd_addr2 = '0; bus.rd_use2 = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        rst_n = 1'b0;

        // 1: reset with random, active inputs
        for (int k = 0; k < 3; k++) begin
            bus.rd_addr1 = 4'($urandom_range(1, 15));
            bus.rd_addr2 = 4'($urandom_range(1, 15));
            bus.rd_use1 = 1'b1; bus.rd_use2 = 1'b1;
            bus.wr_en = 1'b1; bus.wr_addr = bus.rd_addr1; bus.wr_data = 16'($urandom);
            bus.iss_en = 1'b1; bus.iss_addr = 4'($urandom);
            #1;
            check("rst_rd1",   32'(bus.rd_data1), 32'h0);
            check("rst_rd2",   32'(bus.rd_data2), 32'h0);
            check("rst_busy",  32'({bus.busy1, bus.busy2}), 32'h0);
            check("rst_stall", 32'(bus.stall), 32'h0);
            check("rst_ack",   32'(bus.iss_ack), 32'h0);
            tick();
        end
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr1 = 4'(i);
            bus.rd_addr2 = 4'(15 - i);
            #1;
            check("post_rst_rd1", 32'(bus.rd_data1), 32'h0);
            check("post_rst_rd2", 32'(bus.rd_data2), 32'h0);
        end

        // 2: write then read back
        tick();
        bus.rd_addr1 = 4'd1; bus.rd_addr2 = 4'd2;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'hA5A5;
        tick();
        bus.wr_addr = 4'd15; bus.wr_data = 16'hFFFF;
        tick();
        bus.wr_en = 1'b0;
        bus.rd_addr1 = 4'd3; bus.rd_addr2 = 4'd15;
        #1;
        check("wr_rd1", 32'(bus.rd_data1), 32'hA5A5);
        check("wr_rd2", 32'(bus.rd_data2), 32'hFFFF);
        check("wr_rd1_nb", 32'(bus_nb.rd_data1), 32'hA5A5);

        // 3: register 0 ignores writes and issue
        tick();
        bus.rd_addr1 = 4'd0; bus.rd_use1 = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'h1234;
        #1;
        check("z_byp_rd", 32'(bus.rd_data1), 32'h0);
        check("z_byp_busy", 32'(bus.busy1), 32'h0);
        tick();
        bus.wr_en = 1'b0;
        bus.iss_en = 1'b1; bus.iss_addr = 4'd0;
        #1;
        check("z_rd", 32'(bus.rd_data1), 32'h0);
        check("z_ack", 32'(bus.iss_ack), 32'h1);
        tick();
        bus.iss_en = 1'b0;
        #1;
        check("z_rd2", 32'(bus.rd_data1), 32'h0);
        check("z_busy", 32'(bus.busy1), 32'h0);
        check("z_stall", 32'(bus.stall), 32'h0);
        bus.rd_use1 = 1'b0;

        // 4: bypass versus no bypass
        tick();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hBEEF;
        bus.rd_addr1 = 4'd5;
        #1;
        check("byp_rd", 32'(bus.rd_data1), 32'hBEEF);
        check("nobyp_rd", 32'(bus_nb.rd_data1), 32'h0);
        tick();
        bus.wr_en = 1'b0;
        #1;
        check("byp_rd_nx", 32'(bus.rd_data1), 32'hBEEF);
        check("nobyp_rd_nx", 32'(bus_nb.rd_data1), 32'hBEEF);

        // 5: hazard on reg7
        bus.rd_addr1 = 4'd1;
        bus.iss_en = 1'b1; bus.iss_addr = 4'd7;
        #1;
        check("haz_ack", 32'(bus.iss_ack), 32'h1);
        tick();
        bus.iss_addr = 4'd8;
        bus.rd_addr1 = 4'd7; bus.rd_use1 = 1'b1;
        #1;
        check("haz_busy", 32'(bus.busy1), 32'h1);
        check("haz_stall", 32'(bus.stall), 32'h1);
        check("haz_ack0", 32'(bus.iss_ack), 32'h0);
        check("haz_ack0_nb", 32'(bus_nb.iss_ack), 32'h0);
        tick();
        bus.iss_en = 1'b0;
        bus.rd_addr2 = 4'd8;
        bus.rd_use1 = 1'b0;
        #1;
        check("haz_no_set8", 32'(bus.busy2), 32'h0);
        check("haz_nouse", 32'(bus.stall), 32'h0);
        check("haz_busy_hold", 32'(bus.busy1), 32'h1);
        bus.rd_use1 = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h0707;
        #1;
        check("wb_busy_byp", 32'(bus.busy1), 32'h0);
        check("wb_stall_byp", 32'(bus.stall), 32'h0);
        check("wb_busy_nb", 32'(bus_nb.busy1), 32'h1);
        check("wb_stall_nb", 32'(bus_nb.stall), 32'h1);
        tick();
        bus.wr_en = 1'b0;
        #1;
        check("wb_busy_nx", 32'(bus.busy1), 32'h0);
        check("wb_busy_nb_nx", 32'(bus_nb.busy1), 32'h0);
        check("wb_rd_nb", 32'(bus_nb.rd_data1), 32'h0707);

        // 6: issue and writeback to reg9 together, then reset mid-stall
        bus.rd_use1 = 1'b0;
        bus.iss_en = 1'b1; bus.iss_addr = 4'd9;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 16'h9999;
        #1;
        check("sim_ack", 32'(bus.iss_ack), 32'h1);
        tick();
        idle();
        bus.rd_addr1 = 4'd9; bus.rd_use1 = 1'b1;
        #1;
        check("sim_pend", 32'(bus.busy1), 32'h1);
        check("sim_stall", 32'(bus.stall), 32'h1);
        check("sim_data", 32'(bus.rd_data1), 32'h9999);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(bus.stall), 32'h0);
        check("mid_rst_rd", 32'(bus.rd_data1), 32'h0);
        check("mid_rst_busy", 32'(bus.busy1), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("after_rst_rd", 32'(bus.rd_data1), 32'h0);
        check("after_rst_busy", 32'(bus.busy1), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
